// File: rtl/morse_tx.sv
// Serial on/off pattern transmitter: sends a left-aligned pattern MSB-first, DIV clocks per bit.
// Define MORSE_TX_GAP_EN to append GAP_TICKS silent units (busy held) before done.
module morse_tx #(
    parameter int unsigned PAT_W     = 14,
    parameter int unsigned DIV       = 25000000,
    parameter int unsigned LEN_W     = $clog2(PAT_W + 1),
    parameter int unsigned GAP_TICKS = 3
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = $clog2(PAT_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

`ifdef MORSE_TX_GAP_EN
    localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    logic [GAP_W-1:0] gap_q;
`else
    typedef enum logic [1:0] {StIdle, StSend} state_e;
`endif

    state_e           state_q;
    logic [PAT_W-1:0] shift_q;
    logic [BIT_W-1:0] bits_q;
    logic [DIV_W-1:0] div_q;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;

    logic [BIT_W-1:0] len_n;
    logic [PAT_W-1:0] shift_nx;

    always_comb begin
        len_n = BIT_W'(len);
        if (32'(len) > PAT_W) begin
            len_n = BIT_W'(PAT_W);
        end
        shift_nx = shift_q << 1;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            bits_q  <= '0;
            div_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MORSE_TX_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (len_n != '0) begin
                            shift_q <= pat;
                            bits_q  <= len_n;
                            div_q   <= DIV_LAST;
                            tx_q    <= pat[PAT_W-1];
                            busy_q  <= 1'b1;
                            state_q <= StSend;
                        end else begin
                            // Empty pattern completes at once and skips any gap.
                            done_q <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (abort) begin
                        state_q <= StIdle;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (div_q != '0) begin
                        div_q <= div_q - 1'b1;
                    end else begin
                        div_q  <= DIV_LAST;
                        bits_q <= bits_q - 1'b1;
                        if (bits_q > BIT_W'(1)) begin
                            shift_q <= shift_nx;
                            tx_q    <= shift_nx[PAT_W-1];
                        end else begin
                            tx_q <= 1'b0;
`ifdef MORSE_TX_GAP_EN
                            if (GAP_TICKS != 0) begin
                                gap_q   <= GAP_LAST;
                                state_q <= StGap;
                            end else begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
`else
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef MORSE_TX_GAP_EN
                StGap: begin
                    if (abort) begin
                        state_q <= StIdle;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (div_q != '0) begin
                        div_q <= div_q - 1'b1;
                    end else begin
                        div_q <= DIV_LAST;
                        if (gap_q == '0) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            gap_q <= gap_q - 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
